// File: rtl/idi_source.sv
// IDI request initiator: queues host commands, issues them one at a time on the
// IDI valid/ready link and returns captured read data on a backpressured port.
module idi_source #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              valid,
  input  logic              ready,
  output logic              is_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              err_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 1 + ADDR_W + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_MAX_M1 = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} state_t;
  state_t state;

  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [CW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [TW-1:0] stall_cnt;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr[PW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {cmd_is_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= 1'b0;
      is_write    <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      wr_count    <= '0;
      rd_count    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {is_write, addr, wdata} <= head;
            valid <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ready) begin
            valid <= 1'b0;
            if (is_write) begin
              wr_count <= wr_count + 16'd1;
              state    <= IDLE;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          resp_rdata <= rdata;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rd_count   <= rd_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Stall watchdog only flags; the held request is never aborted.
      if (state == REQ && !ready) begin
        if (stall_cnt != T_MAX)    stall_cnt   <= stall_cnt + 1'b1;
        if (stall_cnt == T_MAX_M1) err_timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_idi_source.sv
// Directed bench for idi_source: table of single transactions plus hand-written
// sequences for FIFO full, response backpressure, stall timeout and reset.
module tb_idi_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_write = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        valid;
  logic        ready = 1'b0;
  logic        is_write;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'hBAD0BAD0;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  idi_source #(.FIFO_DEPTH(4), .ADDR_W(64), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .valid(valid), .ready(ready), .is_write(is_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .wr_count(wr_count), .rd_count(rd_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [63:0] a;
    logic [31:0] wd;
    logic [31:0] sink_rd;
    int          stall;
    logic [31:0] exp_rd;
    logic [15:0] exp_wr_cnt;
    logic [15:0] exp_rd_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; ready = 1'b0; resp_ready = 1'b0; rdata = 32'hBAD0BAD0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_cmd(input logic w, input logic [63:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_is_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (valid) break;
      @(negedge clk);
    end
    check(nm, valid, 1);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    push_cmd(v.is_wr, v.a, v.wd);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_valid({nm, "_valid_timeout"});
    check({nm, "_addr"}, addr, v.a);
    check({nm, "_is_write"}, is_write, v.is_wr);
    if (v.is_wr) check({nm, "_wdata"}, wdata, v.wd);
    repeat (v.stall) @(negedge clk);
    check({nm, "_held_valid"}, valid, 1);
    check({nm, "_held_addr"}, addr, v.a);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({nm, "_valid_drop"}, valid, 0);
    if (!v.is_wr) begin
      check({nm, "_rdwait_resp"}, resp_valid, 0);
      rdata = v.sink_rd;
      @(negedge clk);
      rdata = 32'hBAD0BAD0;
      check({nm, "_resp_valid"}, resp_valid, 1);
      check({nm, "_resp_rdata"}, resp_rdata, v.exp_rd);
      @(negedge clk);
      check({nm, "_resp_done"}, resp_valid, 0);
    end
    check({nm, "_wr_count"}, wr_count, v.exp_wr_cnt);
    check({nm, "_rd_count"}, rd_count, v.exp_rd_cnt);
  endtask

  initial begin
    int  n;
    bit  drop;

    vecs[0] = '{1'b0, 64'h2000,                32'h0,        32'h12345678, 0, 32'h12345678, 16'd1, 16'd1};
    vecs[1] = '{1'b1, 64'h0000_0001_0000_0040, 32'hCAFEF00D, 32'h0,        3, 32'h0,        16'd2, 16'd1};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0,        32'hA5A55A5A, 5, 32'hA5A55A5A, 16'd2, 16'd2};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        16'd3, 16'd2};
    vecs[4] = '{1'b0, 64'h0,                   32'h0,        32'h00000000, 1, 32'h00000000, 16'd3, 16'd3};
    vecs[5] = '{1'b0, 64'h8000_0000_0000_0008, 32'h0,        32'h80000001, 2, 32'h80000001, 16'd3, 16'd4};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_addr", addr, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write with exact two-cycle issue latency
    push_cmd(1'b1, 64'h1000, 32'hDEADBEEF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_lat_valid_n1", valid, 0);
    check("wr_lat_busy_n1", busy, 1);
    @(negedge clk);
    check("wr_lat_valid_n2", valid, 1);
    check("wr_addr", addr, 64'h1000);
    check("wr_wdata", wdata, 32'hDEADBEEF);
    check("wr_is_write", is_write, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("wr_valid_drop", valid, 0);
    check("wr_count_1", wr_count, 1);
    check("wr_no_resp", resp_valid, 0);

    // Table of single transactions
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);
    check("table_no_err", err_timeout, 0);
    check("table_idle_busy", busy, 0);

    // FIFO full: one in REQ, four queued, sixth held off until space frees
    do_reset();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("full_push%0d_ready", k), cmd_ready, 1);
      push_cmd(1'b1, 64'h100 + 64'(k), 32'h5000 + 32'(k));
      @(negedge clk);
    end
    push_cmd(1'b1, 64'h105, 32'h5005);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_first_in_req", addr, 64'h100);
    repeat (3) begin
      @(negedge clk);
      check("full_cmd_ready_hold", cmd_ready, 0);
    end
    ready = 1'b1;
    n = 0;
    drop = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      if (valid) begin
        check($sformatf("full_order%0d", n), addr, 64'h100 + 64'(n));
        n++;
      end
      if (drop) begin cmd_valid = 1'b0; drop = 0; end
      if (cmd_valid && cmd_ready) drop = 1;
      @(negedge clk);
    end
    ready = 1'b0;
    check("full_completed", n, 6);
    check("full_wr_count", wr_count, 6);
    check("full_cmd_ready_end", cmd_ready, 1);

    // Response backpressure with a queued command behind the read
    do_reset();
    push_cmd(1'b0, 64'h3000, 32'h0);
    @(negedge clk);
    push_cmd(1'b1, 64'h3100, 32'h31313131);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_valid("bp_valid_timeout");
    check("bp_rd_addr", addr, 64'h3000);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    rdata = 32'h600DF00D;
    @(negedge clk);
    rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 10; c++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_rdata", resp_rdata, 32'h600DF00D);
      check("bp_no_issue", valid, 0);
      @(negedge clk);
    end
    check("bp_rd_count0", rd_count, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_resp_done", resp_valid, 0);
    check("bp_rd_count1", rd_count, 1);
    wait_valid("bp_second_timeout");
    check("bp_second_addr", addr, 64'h3100);
    check("bp_second_is_write", is_write, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("bp_wr_count", wr_count, 1);

    // Stall timeout with TIMEOUT=8
    do_reset();
    push_cmd(1'b1, 64'h4000, 32'h44444444);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_valid("to_valid_timeout");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("to_err_after%0d", k), err_timeout, (k >= 8) ? 1'b1 : 1'b0);
      check("to_valid_held", valid, 1);
      check("to_addr_held", addr, 64'h4000);
      check("to_wdata_held", wdata, 32'h44444444);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("to_valid_drop", valid, 0);
    check("to_wr_count", wr_count, 1);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err_timeout, 1);

    // Reset in RDWAIT with two commands queued
    do_reset();
    resp_ready = 1'b1;
    push_cmd(1'b0, 64'h5000, 32'h0);
    @(negedge clk);
    push_cmd(1'b1, 64'h5100, 32'h51);
    @(negedge clk);
    push_cmd(1'b1, 64'h5200, 32'h52);
    check("rr_valid", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ready = 1'b0;
    check("rr_busy_before", busy, 1);
    check("rr_in_rdwait", valid, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rr_valid_async", valid, 0);
    check("rr_resp_valid_async", resp_valid, 0);
    check("rr_busy_async", busy, 0);
    check("rr_rd_count", rd_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rr_no_issue", valid, 0);
      check("rr_idle", busy, 0);
      check("rr_cmd_ready", cmd_ready, 1);
    end
    check("rr_rd_count_end", rd_count, 0);
    check("rr_wr_count_end", wr_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
